// File: rtl/fa16_rev_pkg.sv
// rtl/fa16_rev_pkg.sv - shared types for the fa16_rev sequencer
package fa16_rev_pkg;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] s;
        logic [W-1:0] a_b;
        logic         c0_b;
        logic         c15;
    } hist_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TURN = 3'd1,
        ST_FWD  = 3'd2,
        ST_REV  = 3'd3,
        ST_RESP = 3'd4
    } seq_state_t;

endpackage

// File: rtl/rev_hist_stack.sv
// rtl/rev_hist_stack.sv - history LIFO of forward macro outputs
module rev_hist_stack
    import fa16_rev_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  hist_t                    din,
    output hist_t                    top,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    hist_t          mem [DEPTH];
    logic [AW-1:0]  top_idx;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign top_idx = AW'(count - 1'b1);
    assign top     = mem[top_idx];

    // Contents are don't-care after reset, so only the pointer is reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[count[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (do_push) begin
            count <= count + 1'b1;
        end else if (do_pop) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/fa16_rev_seq.sv
// rtl/fa16_rev_seq.sv - forward/reverse sequencer for the fa16_rev reversible adder
module fa16_rev_seq
    import fa16_rev_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int SETTLE_CYC = 2,
    parameter int CHECK_EN   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fwd_valid,
    output logic                    fwd_ready,
    input  logic [15:0]             fwd_a,
    input  logic [15:0]             fwd_b,
    input  logic                    fwd_cin,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [15:0]             res_s,
    output logic                    res_cout,
    input  logic                    rev_valid,
    output logic                    rev_ready,
    output logic                    rec_valid,
    input  logic                    rec_ready,
    output logic [15:0]             rec_a,
    output logic [15:0]             rec_b,
    output logic                    rec_cin,
    output logic                    rec_err,
    output logic [$clog2(DEPTH):0]  depth,
    output logic                    dir,
    output logic [15:0]             f_a,
    output logic [15:0]             f_b,
    output logic                    f_c0_f,
    output logic                    f_z,
    input  logic [15:0]             f_s,
    input  logic [15:0]             f_a_b,
    input  logic                    f_c0_b,
    input  logic                    f_c15,
    output logic [15:0]             r_s,
    output logic [15:0]             r_a_b,
    output logic                    r_c0_b,
    output logic                    r_c15,
    input  logic [15:0]             r_a,
    input  logic [15:0]             r_b,
    input  logic                    r_c0_f,
    input  logic                    r_z
);
    localparam int CNT_W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);

    seq_state_t  state;
    logic [CNT_W-1:0] cnt;
    logic        settle_done;
    logic        full;
    logic        empty;
    logic        rev_fire;
    logic        fwd_fire;
    logic        push;
    hist_t       top;
    hist_t       push_data;

    assign fwd_ready   = (state == ST_IDLE) && !full && !res_valid;
    assign rev_ready   = (state == ST_IDLE) && !empty && !rec_valid;
    assign rev_fire    = rev_valid && rev_ready;
    assign fwd_fire    = fwd_valid && fwd_ready && !rev_fire;
    // Operands settle for SETTLE_CYC full cycles; the edge after that samples.
    assign settle_done = (cnt == CNT_W'(SETTLE_CYC));
    assign push        = (state == ST_FWD) && settle_done;
    assign push_data   = '{s: f_s, a_b: f_a_b, c0_b: f_c0_b, c15: f_c15};
    assign f_z         = 1'b0;

    rev_hist_stack #(.DEPTH(DEPTH)) u_hist (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (rev_fire),
        .din   (push_data),
        .top   (top),
        .full  (full),
        .empty (empty),
        .count (depth)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            dir       <= 1'b0;
            f_a       <= '0;
            f_b       <= '0;
            f_c0_f    <= 1'b0;
            r_s       <= '0;
            r_a_b     <= '0;
            r_c0_b    <= 1'b0;
            r_c15     <= 1'b0;
            res_valid <= 1'b0;
            res_s     <= '0;
            res_cout  <= 1'b0;
            rec_valid <= 1'b0;
            rec_a     <= '0;
            rec_b     <= '0;
            rec_cin   <= 1'b0;
            rec_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (rev_fire) begin
                        r_s    <= top.s;
                        r_a_b  <= top.a_b;
                        r_c0_b <= top.c0_b;
                        r_c15  <= top.c15;
                        state  <= dir ? ST_REV : ST_TURN;
                    end else if (fwd_fire) begin
                        f_a    <= fwd_a;
                        f_b    <= fwd_b;
                        f_c0_f <= fwd_cin;
                        state  <= dir ? ST_TURN : ST_FWD;
                    end
                end
                ST_TURN: begin
                    dir   <= ~dir;
                    state <= dir ? ST_FWD : ST_REV;
                end
                ST_FWD: begin
                    if (settle_done) begin
                        res_s     <= f_s;
                        res_cout  <= f_c15;
                        res_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_REV: begin
                    if (settle_done) begin
                        rec_a     <= r_a;
                        rec_b     <= r_b;
                        rec_cin   <= r_c0_f;
                        rec_err   <= (CHECK_EN != 0) && (r_z || (r_a != r_a_b));
                        rec_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if ((res_valid && res_ready) || (rec_valid && rec_ready)) begin
                        res_valid <= 1'b0;
                        rec_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fa16_rev_seq.sv
// tb/tb_fa16_rev_seq.sv - directed bench for fa16_rev_seq with a behavioural fa16_rev model
module tb_fa16_rev_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fwd_valid = 1'b0, fwd_ready;
    logic [15:0] fwd_a = '0, fwd_b = '0;
    logic        fwd_cin = 1'b0;
    logic        res_valid, res_ready = 1'b0;
    logic [15:0] res_s;
    logic        res_cout;
    logic        rev_valid = 1'b0, rev_ready;
    logic        rec_valid, rec_ready = 1'b0;
    logic [15:0] rec_a, rec_b;
    logic        rec_cin, rec_err;
    logic [3:0]  depth;
    logic        dir;
    logic [15:0] f_a, f_b, f_s, f_a_b;
    logic        f_c0_f, f_z, f_c0_b, f_c15;
    logic [15:0] r_s, r_a_b, r_a, r_b;
    logic        r_c0_b, r_c15, r_c0_f, r_z;
    logic        force_z = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fa16_rev_seq #(.DEPTH(8), .SETTLE_CYC(2), .CHECK_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_cin(fwd_cin),
        .res_valid(res_valid), .res_ready(res_ready), .res_s(res_s), .res_cout(res_cout),
        .rev_valid(rev_valid), .rev_ready(rev_ready),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_a(rec_a), .rec_b(rec_b),
        .rec_cin(rec_cin), .rec_err(rec_err), .depth(depth), .dir(dir),
        .f_a(f_a), .f_b(f_b), .f_c0_f(f_c0_f), .f_z(f_z),
        .f_s(f_s), .f_a_b(f_a_b), .f_c0_b(f_c0_b), .f_c15(f_c15),
        .r_s(r_s), .r_a_b(r_a_b), .r_c0_b(r_c0_b), .r_c15(r_c15),
        .r_a(r_a), .r_b(r_b), .r_c0_f(r_c0_f), .r_z(r_z)
    );

    // Behavioural reversible adder: forward keeps a copy of A and cin, backward subtracts.
    logic [16:0] fsum, bdiff;
    always_comb begin
        fsum   = {1'b0, f_a} + {1'b0, f_b} + {16'd0, f_c0_f};
        f_s    = fsum[15:0];
        f_c15  = fsum[16];
        f_a_b  = f_a;
        f_c0_b = f_c0_f;
        bdiff  = {r_c15, r_s} - {1'b0, r_a_b} - {16'd0, r_c0_b};
        r_b    = bdiff[15:0];
        r_a    = r_a_b;
        r_c0_f = r_c0_b;
        r_z    = force_z;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_fwd(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          output logic [15:0] s, output logic c, output int lat);
        int t;
        t = 0;
        @(negedge clk);
        while (!fwd_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!fwd_ready) chk("fwd_ready_timeout", 32'(fwd_ready), 32'd1);
        fwd_a = a; fwd_b = b; fwd_cin = cin; fwd_valid = 1'b1;
        @(posedge clk);
        #1 fwd_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!res_valid) chk("res_valid_timeout", 32'(res_valid), 32'd1);
        s = res_s; c = res_cout;
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic do_rev(output logic [15:0] a, output logic [15:0] b, output logic cin,
                          output logic err, output int lat);
        int t;
        t = 0;
        @(negedge clk);
        while (!rev_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!rev_ready) chk("rev_ready_timeout", 32'(rev_ready), 32'd1);
        rev_valid = 1'b1;
        @(posedge clk);
        #1 rev_valid = 1'b0;
        lat = 0;
        while (!rec_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!rec_valid) chk("rec_valid_timeout", 32'(rec_valid), 32'd1);
        a = rec_a; b = rec_b; cin = rec_cin; err = rec_err;
        rec_ready = 1'b1;
        @(posedge clk);
        #1 rec_ready = 1'b0;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] exp_s;
        logic        exp_cout;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [15:0] s, ra, rb;
        logic        c, rc, re;
        int          lat;

        vecs[0] = '{16'h1234, 16'h0FF0, 1'b0, 16'h2224, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1};
        vecs[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[3] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_dir", 32'(dir), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_rec_valid", 32'(rec_valid), 32'd0);
        chk("rst_rec_err", 32'(rec_err), 32'd0);
        chk("rst_f_a", 32'(f_a), 32'd0);
        chk("rst_r_s", 32'(r_s), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rst_fwd_ready", 32'(fwd_ready), 32'd1);
        chk("rst_rev_ready", 32'(rev_ready), 32'd0);

        for (int i = 0; i < 4; i++) begin
            do_fwd(vecs[i].a, vecs[i].b, vecs[i].cin, s, c, lat);
            chk("vec_res_s", 32'(s), 32'(vecs[i].exp_s));
            chk("vec_res_cout", 32'(c), 32'(vecs[i].exp_cout));
            chk("vec_fwd_lat", 32'(lat), 32'd3);
            chk("vec_depth", 32'(depth), 32'(i + 1));
        end

        // Fwd then rev back-to-back inserts exactly one TURN.
        for (int i = 3; i >= 0; i--) begin
            do_rev(ra, rb, rc, re, lat);
            chk("vec_rec_a", 32'(ra), 32'(vecs[i].a));
            chk("vec_rec_b", 32'(rb), 32'(vecs[i].b));
            chk("vec_rec_cin", 32'(rc), 32'(vecs[i].cin));
            chk("vec_rec_err", 32'(re), 32'd0);
            chk("vec_rev_lat", 32'(lat), (i == 3) ? 32'd4 : 32'd3);
            chk("vec_rev_dir", 32'(dir), 32'd1);
        end
        chk("drain_depth", 32'(depth), 32'd0);

        do_fwd(16'd1, 16'd2, 1'b0, s, c, lat);
        chk("turn_fwd_lat", 32'(lat), 32'd4);
        chk("turn_fwd_dir", 32'(dir), 32'd0);
        do_fwd(16'd3, 16'd4, 1'b1, s, c, lat);
        do_fwd(16'd5, 16'd6, 1'b0, s, c, lat);
        chk("lifo_depth3", 32'(depth), 32'd3);
        do_rev(ra, rb, rc, re, lat);
        chk("lifo_pop0", {ra, rb[14:0], rc}, {16'd5, 15'd6, 1'b0});
        do_rev(ra, rb, rc, re, lat);
        chk("lifo_pop1", {ra, rb[14:0], rc}, {16'd3, 15'd4, 1'b1});
        do_rev(ra, rb, rc, re, lat);
        chk("lifo_pop2", {ra, rb[14:0], rc}, {16'd1, 15'd2, 1'b0});
        chk("lifo_err", 32'(re), 32'd0);
        chk("lifo_depth0", 32'(depth), 32'd0);

        for (int i = 0; i < 8; i++) begin
            do_fwd(16'(i * 7), 16'(i * 3 + 1), i[0], s, c, lat);
            chk("fill_s", 32'(s), 32'(16'(i * 10 + 1 + i % 2)));
        end
        @(negedge clk);
        chk("full_depth", 32'(depth), 32'd8);
        chk("full_fwd_ready", 32'(fwd_ready), 32'd0);
        for (int i = 7; i >= 0; i--) begin
            do_rev(ra, rb, rc, re, lat);
            chk("drain_b", 32'(rb), 32'(16'(i * 3 + 1)));
        end
        @(negedge clk);
        chk("empty_depth", 32'(depth), 32'd0);
        chk("empty_rev_ready", 32'(rev_ready), 32'd0);

        // Both requests eligible in IDLE: reverse must win.
        do_fwd(16'h0ABC, 16'h0123, 1'b1, s, c, lat);
        @(negedge clk);
        fwd_a = 16'h1111; fwd_b = 16'h2222; fwd_cin = 1'b0;
        fwd_valid = 1'b1; rev_valid = 1'b1;
        @(posedge clk);
        #1 fwd_valid = 1'b0; rev_valid = 1'b0;
        lat = 0;
        while (!rec_valid && !res_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("prio_rec_valid", 32'(rec_valid), 32'd1);
        chk("prio_res_valid", 32'(res_valid), 32'd0);
        chk("prio_rec_a", 32'(rec_a), 32'h0ABC);
        rec_ready = 1'b1;
        @(posedge clk);
        #1 rec_ready = 1'b0;
        chk("prio_depth", 32'(depth), 32'd0);

        do_fwd(16'hAAAA, 16'h5555, 1'b1, s, c, lat);
        force_z = 1'b1;
        do_rev(ra, rb, rc, re, lat);
        force_z = 1'b0;
        chk("zcheck_err", 32'(re), 32'd1);

        // Reset while FWD is in progress (dir is 1 here, so TURN precedes FWD).
        do_fwd(16'h0042, 16'h0001, 1'b0, s, c, lat);
        @(negedge clk);
        fwd_a = 16'h7777; fwd_b = 16'h0001; fwd_cin = 1'b0; fwd_valid = 1'b1;
        @(posedge clk);
        #1 fwd_valid = 1'b0;
        @(posedge clk);
        #1 chk("pre_rst_f_a", 32'(f_a), 32'h7777);
        rst_n = 1'b0;
        #1;
        chk("midrst_depth", 32'(depth), 32'd0);
        chk("midrst_f_a", 32'(f_a), 32'd0);
        chk("midrst_dir", 32'(dir), 32'd0);
        chk("midrst_res_valid", 32'(res_valid), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("postrst_res_valid", 32'(res_valid), 32'd0);
        chk("postrst_depth", 32'(depth), 32'd0);
        chk("postrst_fwd_ready", 32'(fwd_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
